// File: rtl/axil_cfg_pkg.sv
// Shared types and constants for the AXI4-Lite configuration master and its helpers.
package axil_cfg_pkg;

  // Defaults track CGRA_AXI_ADDR_WIDTH / CGRA_AXI_DATA_WIDTH from global_buffer_param.
  localparam int unsigned AXIL_ADDR_WIDTH = 13;
  localparam int unsigned AXIL_DATA_WIDTH = 32;

  localparam logic [1:0] AXIL_OKAY   = 2'b00;
  localparam logic [1:0] AXIL_SLVERR = 2'b10;
  localparam logic [1:0] AXIL_DECERR = 2'b11;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StWrReq  = 3'd1,
    StWrResp = 3'd2,
    StRdReq  = 3'd3,
    StRdData = 3'd4,
    StRsp    = 3'd5
  } axil_state_e;

  typedef struct packed {
    logic                       write;
    logic [AXIL_ADDR_WIDTH-1:0] addr;
    logic [AXIL_DATA_WIDTH-1:0] wdata;
  } axil_cmd_t;

  typedef struct packed {
    logic [AXIL_DATA_WIDTH-1:0] rdata;
    logic [1:0]                 resp;
    logic                       timeout;
  } axil_rsp_t;

  // States in which the master is waiting on the slave and the timeout runs.
  function automatic logic is_wait_state(input axil_state_e s);
    return (s == StWrReq) || (s == StWrResp) || (s == StRdReq) || (s == StRdData);
  endfunction

endpackage

// File: rtl/axil_timeout_ctr.sv
// Wait-state watchdog: counts enabled cycles since the last clear and flags the final one.
module axil_timeout_ctr #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CntW-1:0] LastCnt = (TIMEOUT_CYCLES > 1) ? CntW'(TIMEOUT_CYCLES - 1) : '0;
  localparam bit Enabled = (TIMEOUT_CYCLES != 0);

  logic [CntW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt_q <= '0;
    end else if (enable) begin
      cnt_q <= cnt_q + CntW'(1);
    end
  end

  // Fires on the TIMEOUT_CYCLES-th enabled cycle, so the wait lasts exactly that long.
  assign expire = Enabled && enable && (cnt_q == LastCnt);

endmodule

// File: rtl/axil_cfg_master.sv
// Single-outstanding AXI4-Lite master turning valid/ready register commands into transactions.
module axil_cfg_master
  import axil_cfg_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = AXIL_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH     = AXIL_DATA_WIDTH,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [1:0]            rsp_resp,
  output logic                  rsp_timeout,
  output logic [ADDR_WIDTH-1:0] m_awaddr,
  output logic                  m_awvalid,
  input  logic                  m_awready,
  output logic [DATA_WIDTH-1:0] m_wdata,
  output logic                  m_wvalid,
  input  logic                  m_wready,
  input  logic [1:0]            m_bresp,
  input  logic                  m_bvalid,
  output logic                  m_bready,
  output logic [ADDR_WIDTH-1:0] m_araddr,
  output logic                  m_arvalid,
  input  logic                  m_arready,
  input  logic [DATA_WIDTH-1:0] m_rdata,
  input  logic [1:0]            m_rresp,
  input  logic                  m_rvalid,
  output logic                  m_rready
);

  axil_state_e           state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic                  awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
  logic                  arvalid_q, arvalid_d, rready_q, rready_d;
  logic [1:0]            resp_q, resp_d;
  logic                  timeout_q, timeout_d;
  logic                  tmo_clear, tmo_enable, tmo_expire, abort;

  assign tmo_enable = is_wait_state(state_q);
  assign tmo_clear  = (state_d != state_q);

  axil_timeout_ctr #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk   (clk),
    .reset (reset),
    .clear (tmo_clear),
    .enable(tmo_enable),
    .expire(tmo_expire)
  );

  // Gated by reset so no command can be taken while the block is being cleared.
  assign cmd_ready = (state_q == StIdle) && !reset;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    bready_d  = bready_q;
    arvalid_d = arvalid_q;
    rready_d  = rready_q;
    rdata_d   = rdata_q;
    resp_d    = resp_q;
    timeout_d = timeout_q;
    abort     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (cmd_valid && cmd_ready) begin
          addr_d = cmd_addr;
          if (cmd_write) begin
            wdata_d   = cmd_wdata;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = StWrReq;
          end else begin
            arvalid_d = 1'b1;
            state_d   = StRdReq;
          end
        end
      end
      StWrReq: begin
        awvalid_d = awvalid_q && !m_awready;
        wvalid_d  = wvalid_q && !m_wready;
        if (!awvalid_d && !wvalid_d) begin
          bready_d = 1'b1;
          state_d  = StWrResp;
        end else begin
          abort = tmo_expire;
        end
      end
      StWrResp: begin
        if (m_bvalid) begin
          resp_d   = m_bresp;
          rdata_d  = '0;
          bready_d = 1'b0;
          state_d  = StRsp;
        end else begin
          abort = tmo_expire;
        end
      end
      StRdReq: begin
        if (m_arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = StRdData;
        end else begin
          abort = tmo_expire;
        end
      end
      StRdData: begin
        if (m_rvalid) begin
          rdata_d  = m_rdata;
          resp_d   = m_rresp;
          rready_d = 1'b0;
          state_d  = StRsp;
        end else begin
          abort = tmo_expire;
        end
      end
      StRsp: begin
        if (rsp_ready) begin
          timeout_d = 1'b0;
          state_d   = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    // A handshake in the expiry cycle already moved on above, so abort only sees true stalls.
    if (abort) begin
      awvalid_d = 1'b0;
      wvalid_d  = 1'b0;
      bready_d  = 1'b0;
      arvalid_d = 1'b0;
      rready_d  = 1'b0;
      rdata_d   = '0;
      resp_d    = AXIL_SLVERR;
      timeout_d = 1'b1;
      state_d   = StRsp;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      addr_q    <= '0;
      wdata_q   <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      rdata_q   <= '0;
      resp_q    <= AXIL_OKAY;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      bready_q  <= bready_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
      rdata_q   <= rdata_d;
      resp_q    <= resp_d;
      timeout_q <= timeout_d;
    end
  end

  assign rsp_valid   = (state_q == StRsp);
  assign rsp_rdata   = rdata_q;
  assign rsp_resp    = resp_q;
  assign rsp_timeout = timeout_q;
  assign m_awaddr    = addr_q;
  assign m_awvalid   = awvalid_q;
  assign m_wdata     = wdata_q;
  assign m_wvalid    = wvalid_q;
  assign m_bready    = bready_q;
  assign m_araddr    = addr_q;
  assign m_arvalid   = arvalid_q;
  assign m_rready    = rready_q;

endmodule

// File: tb/tb_axil_cfg_master.sv
// Directed bench for axil_cfg_master with a channel-level reference model checked every cycle.
module tb_axil_cfg_master;

  localparam int unsigned AW = 13;
  localparam int unsigned DW = 32;
  localparam int unsigned T  = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid, rsp_ready, rsp_timeout;
  logic [DW-1:0] rsp_rdata;
  logic [1:0]    rsp_resp;
  logic [AW-1:0] m_awaddr, m_araddr;
  logic          m_awvalid, m_awready, m_wvalid, m_wready;
  logic [DW-1:0] m_wdata, m_rdata;
  logic [1:0]    m_bresp, m_rresp;
  logic          m_bvalid, m_bready, m_arvalid, m_arready, m_rvalid, m_rready;

  axil_cfg_master #(
    .ADDR_WIDTH    (AW),
    .DATA_WIDTH    (DW),
    .TIMEOUT_CYCLES(T)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_write  (cmd_write),
    .cmd_addr   (cmd_addr),
    .cmd_wdata  (cmd_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_resp   (rsp_resp),
    .rsp_timeout(rsp_timeout),
    .m_awaddr   (m_awaddr),
    .m_awvalid  (m_awvalid),
    .m_awready  (m_awready),
    .m_wdata    (m_wdata),
    .m_wvalid   (m_wvalid),
    .m_wready   (m_wready),
    .m_bresp    (m_bresp),
    .m_bvalid   (m_bvalid),
    .m_bready   (m_bready),
    .m_araddr   (m_araddr),
    .m_arvalid  (m_arvalid),
    .m_arready  (m_arready),
    .m_rdata    (m_rdata),
    .m_rresp    (m_rresp),
    .m_rvalid   (m_rvalid),
    .m_rready   (m_rready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int c0 = 0;
  int dut_nrsp = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: one pending flag per AXI channel plus the expected response record.
  bit          e_busy, e_aw, e_w, e_b, e_ar, e_r, e_rsp, e_just_reset;
  bit          e_to;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_wdata, e_rdata;
  logic [1:0]  e_resp;
  int          e_cnt;

  task automatic model_finish(input logic [DW-1:0] rd, input logic [1:0] rs, input bit to);
    e_aw = 0; e_w = 0; e_b = 0; e_ar = 0; e_r = 0;
    e_rsp = 1; e_rdata = rd; e_resp = rs; e_to = to;
  endtask

  always @(negedge clk) begin
    bit exp_ready;
    bit expire_now;
    exp_ready = !e_busy && !reset;
    check("cmd_ready", cmd_ready, exp_ready);
    check("m_awvalid", m_awvalid, e_aw);
    check("m_wvalid", m_wvalid, e_w);
    check("m_bready", m_bready, e_b);
    check("m_arvalid", m_arvalid, e_ar);
    check("m_rready", m_rready, e_r);
    check("rsp_valid", rsp_valid, e_rsp);
    if (e_aw) check("m_awaddr", m_awaddr, e_addr);
    if (e_w) check("m_wdata", m_wdata, e_wdata);
    if (e_ar) check("m_araddr", m_araddr, e_addr);
    if (e_rsp) begin
      check("rsp_rdata", rsp_rdata, e_rdata);
      check("rsp_resp", rsp_resp, e_resp);
      check("rsp_timeout", rsp_timeout, e_to);
    end
    if (e_just_reset) begin
      check("rst_awaddr", m_awaddr, 0);
      check("rst_araddr", m_araddr, 0);
      check("rst_wdata", m_wdata, 0);
      check("rst_rsp_rdata", rsp_rdata, 0);
      check("rst_rsp_resp", rsp_resp, 0);
      check("rst_rsp_timeout", rsp_timeout, 0);
    end
    if (rsp_valid === 1'b1 && rsp_ready === 1'b1) dut_nrsp++;

    expire_now = (T != 0) && (e_cnt + 1 == T);
    e_just_reset = reset;
    if (reset) begin
      e_busy = 0; e_aw = 0; e_w = 0; e_b = 0; e_ar = 0; e_r = 0; e_rsp = 0; e_cnt = 0;
    end else if (e_rsp) begin
      if (rsp_ready) begin
        e_rsp = 0;
        e_busy = 0;
      end
    end else if (!e_busy) begin
      if (cmd_valid) begin
        e_busy = 1;
        e_cnt = 0;
        e_addr = cmd_addr;
        if (cmd_write) begin
          e_aw = 1; e_w = 1; e_wdata = cmd_wdata;
        end else begin
          e_ar = 1;
        end
      end
    end else if (e_aw || e_w) begin
      if (e_aw && m_awready) e_aw = 0;
      if (e_w && m_wready) e_w = 0;
      if (!e_aw && !e_w) begin
        e_b = 1; e_cnt = 0;
      end else if (expire_now) begin
        model_finish('0, 2'd2, 1);
      end else begin
        e_cnt++;
      end
    end else if (e_b) begin
      if (m_bvalid) model_finish('0, m_bresp, 0);
      else if (expire_now) model_finish('0, 2'd2, 1);
      else e_cnt++;
    end else if (e_ar) begin
      if (m_arready) begin
        e_ar = 0; e_r = 1; e_cnt = 0;
      end else if (expire_now) begin
        model_finish('0, 2'd2, 1);
      end else begin
        e_cnt++;
      end
    end else if (e_r) begin
      if (m_rvalid) model_finish(m_rdata, m_rresp, 0);
      else if (expire_now) model_finish('0, 2'd2, 1);
      else e_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Holds the command until accepted; c0 marks the accepting cycle ("cycle 0").
  task automatic issue(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bit ok;
    ok = 0;
    cmd_valid = 1; cmd_write = wr; cmd_addr = a; cmd_wdata = d;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (cmd_ready === 1'b1) begin
        ok = 1;
        c0 = cyc;
        break;
      end
      tick();
    end
    check("cmd_accepted", ok, 1);
    tick();
    cmd_valid = 0;
  endtask

  task automatic wait_rsp(output int lat);
    lat = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (rsp_valid === 1'b1) begin
        lat = cyc - c0;
        break;
      end
    end
    check("rsp_arrives", lat >= 0, 1);
  endtask

  task automatic slave_idle();
    m_awready = 0; m_wready = 0; m_bvalid = 0; m_bresp = 0;
    m_arready = 0; m_rvalid = 0; m_rdata = 0; m_rresp = 0;
  endtask

  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end

  initial begin
    int lat, n_ar, n0, r;
    reset = 1; cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0; rsp_ready = 1;
    slave_idle();
    repeat (3) tick();
    @(negedge clk);
    check("reset_cmd_ready", cmd_ready, 0);
    check("reset_rsp_valid", rsp_valid, 0);
    check("reset_awvalid", m_awvalid, 0);
    tick();
    reset = 0;
    @(negedge clk);
    check("idle_cmd_ready", cmd_ready, 1);
    tick();

    // Zero-wait write.
    m_awready = 1; m_wready = 1; m_bvalid = 1; m_bresp = 0;
    issue(1, 13'h100, 32'hDEADBEEF);
    @(negedge clk);
    check("s1_awvalid_c1", m_awvalid, 1);
    check("s1_wvalid_c1", m_wvalid, 1);
    check("s1_awaddr_c1", m_awaddr, 13'h100);
    wait_rsp(lat);
    check("s1_latency", lat, 3);
    check("s1_resp", rsp_resp, 0);
    check("s1_timeout", rsp_timeout, 0);
    tick();
    slave_idle();

    // Write with W accepted five cycles after AW.
    m_awready = 1;
    issue(1, 13'h200, 32'hDEADBEEF);
    @(negedge clk);
    check("s2_awvalid_c1", m_awvalid, 1);
    tick();
    @(negedge clk);
    check("s2_awvalid_c2", m_awvalid, 0);
    check("s2_wvalid_c2", m_wvalid, 1);
    check("s2_wdata_c2", m_wdata, 32'hDEADBEEF);
    tick();
    n0 = dut_nrsp;
    repeat (3) tick();
    m_wready = 1; m_bvalid = 1; m_bresp = 0;
    wait_rsp(lat);
    check("s2_latency", lat, 8);
    check("s2_resp", rsp_resp, 0);
    tick();
    slave_idle();
    repeat (3) tick();
    check("s2_single_rsp", dut_nrsp - n0, 1);

    // Read with three R wait cycles and SLVERR.
    m_arready = 1;
    issue(0, 13'h004, 32'h0);
    @(negedge clk);
    check("s3_arvalid_c1", m_arvalid, 1);
    check("s3_araddr_c1", m_araddr, 13'h004);
    repeat (4) tick();
    m_rvalid = 1; m_rdata = 32'h12345678; m_rresp = 2;
    wait_rsp(lat);
    check("s3_latency", lat, 6);
    check("s3_rdata", rsp_rdata, 32'h12345678);
    check("s3_resp", rsp_resp, 2);
    check("s3_timeout", rsp_timeout, 0);
    tick();
    slave_idle();

    // AR never accepted: abort after T cycles, then late R is ignored.
    issue(0, 13'h008, 32'h0);
    n_ar = 0;
    lat = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (m_arvalid === 1'b1) n_ar++;
      if (rsp_valid === 1'b1) begin
        lat = cyc - c0;
        break;
      end
    end
    check("s4_arvalid_cycles", n_ar, 8);
    check("s4_latency", lat, 9);
    check("s4_timeout", rsp_timeout, 1);
    check("s4_resp", rsp_resp, 2);
    check("s4_rdata", rsp_rdata, 0);
    tick();
    m_rvalid = 1; m_rdata = 32'hFFFF0000;
    @(negedge clk);
    check("s4_late_rready", m_rready, 0);
    check("s4_timeout_cleared", rsp_timeout, 0);
    check("s4_idle_ready", cmd_ready, 1);
    tick();
    slave_idle();
    m_awready = 1; m_wready = 1; m_bvalid = 1; m_bresp = 0;
    issue(1, 13'h00C, 32'h00C0FFEE);
    wait_rsp(lat);
    check("s4_next_latency", lat, 3);
    check("s4_next_timeout", rsp_timeout, 0);
    check("s4_next_resp", rsp_resp, 0);
    tick();
    slave_idle();

    // Response back-pressured for 10 cycles while a second command waits.
    m_arready = 1; m_rvalid = 1; m_rdata = 32'hCAFEF00D; m_rresp = 0; rsp_ready = 0;
    issue(0, 13'h010, 32'h0);
    wait_rsp(lat);
    check("s5_latency", lat, 3);
    for (int i = 0; i < 10; i++) begin
      tick();
      if (i == 0) begin
        cmd_valid = 1; cmd_write = 1; cmd_addr = 13'h020; cmd_wdata = 32'h55AA55AA;
      end
      @(negedge clk);
      check("s5_hold_valid", rsp_valid, 1);
      check("s5_hold_rdata", rsp_rdata, 32'hCAFEF00D);
      check("s5_hold_cmd_ready", cmd_ready, 0);
    end
    tick();
    slave_idle();
    m_awready = 1; m_wready = 1; m_bvalid = 1; m_bresp = 0; rsp_ready = 1;
    r = cyc;
    issue(1, 13'h020, 32'h55AA55AA);
    check("s5_accept_after_rsp", c0 - r, 1);
    wait_rsp(lat);
    check("s5_second_latency", lat, 3);
    tick();
    slave_idle();

    // Reset while waiting for B, coinciding with a late bvalid.
    m_awready = 1; m_wready = 1;
    n0 = dut_nrsp;
    issue(1, 13'h300, 32'h13579BDF);
    @(negedge clk);
    tick();
    @(negedge clk);
    check("s6_bready_c2", m_bready, 1);
    tick();
    reset = 1; m_bvalid = 1; m_bresp = 2;
    tick();
    reset = 0; m_bvalid = 0;
    @(negedge clk);
    check("s6_awaddr_zero", m_awaddr, 0);
    check("s6_wdata_zero", m_wdata, 0);
    check("s6_bready_zero", m_bready, 0);
    check("s6_rsp_valid_zero", rsp_valid, 0);
    check("s6_awvalid_zero", m_awvalid, 0);
    tick();
    slave_idle();
    check("s6_no_rsp", dut_nrsp - n0, 0);
    m_arready = 1; m_rvalid = 1; m_rdata = 32'h0BADF00D; m_rresp = 0;
    issue(0, 13'h03C, 32'h0);
    wait_rsp(lat);
    check("s6_read_latency", lat, 3);
    check("s6_read_rdata", rsp_rdata, 32'h0BADF00D);
    check("s6_read_resp", rsp_resp, 0);
    tick();
    slave_idle();
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
